// File: rtl/add_share_pkg.sv
// add_share_pkg: constants and types shared by the fp16 adder-sharing arbiter.
package add_share_pkg;

   localparam int FP16_W = 16;

   // Wide enough to index up to 256 requesters; NREQ must stay within that.
   localparam int IDX_W = 8;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      FLUSHED
   } state_e;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tag_t;

endpackage

// File: rtl/add_share_arb_rr_arb.sv
// rr_arb: round-robin selection among NREQ requesters; priority starts after the last grant.
module rr_arb
   import add_share_pkg::*;
#(
   parameter int NREQ = 4
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req_i,
   input  logic             en_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [IDX_W-1:0] hiIdx;
   logic [IDX_W-1:0] loIdx;
   logic             hiFound;
   logic             loFound;

   // Lowest requester at or above the pointer wins, otherwise wrap to the lowest overall.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      hiFound   = 1'b0;
      loFound   = 1'b0;
      hiIdx     = '0;
      loIdx     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_i[i] && !loFound) begin
            loFound = 1'b1;
            loIdx   = IDX_W'(i);
         end
         if (req_i[i] && !hiFound && (IDX_W'(i) >= ptr_q)) begin
            hiFound = 1'b1;
            hiIdx   = IDX_W'(i);
         end
      end
      if (en_i && (hiFound || loFound)) begin
         gnt_idx_o = hiFound ? hiIdx : loIdx;
         for (int i = 0; i < NREQ; i++) begin
            gnt_o[i] = (IDX_W'(i) == gnt_idx_o);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (|gnt_o) begin
         ptr_d = (gnt_idx_o == IDX_W'(NREQ - 1)) ? '0 : gnt_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/add_share_arb.sv
// add_share_arb: NREQ requesters share one fixed-latency fp16 adder, with flush/drain control.
// Define ADD_SHARE_STATS_EN to build the saturating per-requester grant counters.
module add_share_arb
   import add_share_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int ADD_LAT = 3
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*FP16_W-1:0] req_a,
   input  logic [NREQ*FP16_W-1:0] req_b,
   output logic [FP16_W-1:0]      add_a,
   output logic [FP16_W-1:0]      add_b,
   input  logic [FP16_W-1:0]      add_r,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [FP16_W-1:0]      rsp_data,
   input  logic                   flush,
   output logic                   flush_done,
   output logic                   busy,
   output logic [NREQ*16-1:0]     stat_grants
);

   state_e           state_q;
   state_e           state_d;
   tag_t             pipe_q [ADD_LAT];
   tag_t             issueTag;
   logic             grantEn;
   logic [IDX_W-1:0] gntIdx;

   // rst_n gates the grant so req_ready drops the instant reset asserts.
   assign grantEn = rst_n && (state_q == RUN) && !flush;

   rr_arb #(.NREQ(NREQ)) u_rr_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_valid),
      .en_i      (grantEn),
      .gnt_o     (req_ready),
      .gnt_idx_o (gntIdx)
   );

   always_comb begin
      add_a = '0;
      add_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            add_a = req_a[i*FP16_W +: FP16_W];
            add_b = req_b[i*FP16_W +: FP16_W];
         end
      end
   end

   assign issueTag = '{valid: |(req_ready & req_valid), idx: gntIdx};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ADD_LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= issueTag;
         for (int i = 1; i < ADD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   // The last stage lines up with add_r for the operation issued ADD_LAT cycles ago.
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      busy      = 1'b0;
      for (int i = 0; i < ADD_LAT; i++) begin
         busy = busy | pipe_q[i].valid;
      end
      if (pipe_q[ADD_LAT-1].valid) begin
         rsp_data = add_r;
         for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = (pipe_q[ADD_LAT-1].idx == IDX_W'(i));
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (flush) state_d = DRAIN;
         DRAIN:   if (!flush) state_d = RUN;
                  else if (!busy) state_d = FLUSHED;
         FLUSHED: if (!flush) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign flush_done = (state_q == FLUSHED);

`ifdef ADD_SHARE_STATS_EN
   logic [NREQ*16-1:0] stat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i] && (stat_q[i*16 +: 16] != 16'hFFFF)) begin
               stat_q[i*16 +: 16] <= stat_q[i*16 +: 16] + 16'd1;
            end
         end
      end
   end

   assign stat_grants = stat_q;
`else
   assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// tb_add_share_arb: randomized scoreboard bench; the stub adder is exact for small
// non-negative integers encoded as fp16, which is all the stimulus ever uses.
module tb_add_share_arb;

   localparam int NREQ      = 4;
   localparam int ADD_LAT   = 3;
   localparam int M_RUN     = 0;
   localparam int M_DRAIN   = 1;
   localparam int M_FLUSHED = 2;

   typedef struct {
      int          cyc;
      int          idx;
      logic [15:0] data;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*16-1:0]   req_a;
   logic [NREQ*16-1:0]   req_b;
   logic [15:0]          add_a;
   logic [15:0]          add_b;
   logic [15:0]          add_r;
   logic [NREQ-1:0]      rsp_valid;
   logic [15:0]          rsp_data;
   logic                 flush;
   logic                 flush_done;
   logic                 busy;
   logic [NREQ*16-1:0]   stat_grants;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sb[$];
   exp_t monE;
   int   valA [NREQ];
   int   valB [NREQ];
   int   cnt  [NREQ];
   int   mPtr   = 0;
   int   mState = M_RUN;
   int   hold   = 0;

   logic [15:0] sumNow;
   logic [15:0] stage [ADD_LAT];

   add_share_arb #(.NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_r       (add_r),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .flush       (flush),
      .flush_done  (flush_done),
      .busy        (busy),
      .stat_grants (stat_grants)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] enc(input int n);
      int          p;
      int          m;
      logic [15:0] r;
      r = '0;
      if (n > 0) begin
         p = 0;
         for (int b = 0; b < 12; b++) if (n >= (1 << b)) p = b;
         m = ((n << 10) >> p) - 1024;
         r = {1'b0, 5'(p + 15), 10'(m)};
      end
      return r;
   endfunction

   function automatic int dec(input logic [15:0] h);
      int e;
      int v;
      e = int'(h[14:10]);
      v = 1024 + int'(h[9:0]);
      if (e == 0) return 0;
      if (e >= 25) return v << (e - 25);
      return v >> (25 - e);
   endfunction

   function automatic logic [63:0] expStats();
      logic [63:0] s;
      s = '0;
      for (int i = 0; i < NREQ; i++) begin
         s[i*16 +: 16] = (cnt[i] > 65535) ? 16'hFFFF : 16'(cnt[i]);
      end
`ifndef ADD_SHARE_STATS_EN
      s = '0;
`endif
      return s;
   endfunction

   // Stub adder: operands sampled mid-cycle, result appears ADD_LAT cycles later.
   always @(negedge clk) sumNow = enc(dec(add_a) + dec(add_b));

   always @(posedge clk) begin
      stage[0] <= sumNow;
      for (int i = 1; i < ADD_LAT; i++) stage[i] <= stage[i-1];
   end

   assign add_r = stage[ADD_LAT-1];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req_ready"},   64'(req_ready),   64'd0);
      checkOutput({tag, "_rsp_valid"},   64'(rsp_valid),   64'd0);
      checkOutput({tag, "_rsp_data"},    64'(rsp_data),    64'd0);
      checkOutput({tag, "_busy"},        64'(busy),        64'd0);
      checkOutput({tag, "_flush_done"},  64'(flush_done),  64'd0);
      checkOutput({tag, "_stat_grants"}, 64'(stat_grants), 64'd0);
   endtask

   // One clock cycle: drive inputs, predict the grant from the round-robin rules, queue the result.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic f, input bit randOps);
      int              g;
      int              idx;
      bit              mBusy;
      logic [NREQ-1:0] expReady;
      logic [15:0]     expA;
      logic [15:0]     expB;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (randOps) begin
            valA[i] = int'($urandom_range(0, 1000));
            valB[i] = int'($urandom_range(0, 1000));
         end
         req_a[i*16 +: 16] = enc(valA[i]);
         req_b[i*16 +: 16] = enc(valB[i]);
      end
      req_valid = v;
      flush     = f;
      #3;
      g = -1;
      if (mState == M_RUN && !f) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (mPtr + k) % NREQ;
            if (g < 0 && v[idx]) g = idx;
         end
      end
      expReady = '0;
      expA     = '0;
      expB     = '0;
      if (g >= 0) begin
         expReady[g] = 1'b1;
         expA        = enc(valA[g]);
         expB        = enc(valB[g]);
      end
      mBusy = (sb.size() != 0);
      checkOutput("req_ready",   64'(req_ready),   64'(expReady));
      checkOutput("add_a",       64'(add_a),       64'(expA));
      checkOutput("add_b",       64'(add_b),       64'(expB));
      checkOutput("busy",        64'(busy),        64'(mBusy));
      checkOutput("flush_done",  64'(flush_done),  64'(mState == M_FLUSHED));
      checkOutput("stat_grants", 64'(stat_grants), expStats());
      if (g >= 0) begin
         sb.push_back('{cyc: cyc + ADD_LAT, idx: g, data: enc(valA[g] + valB[g])});
         mPtr = (g + 1) % NREQ;
         cnt[g]++;
      end
      case (mState)
         M_RUN:     if (f) mState = M_DRAIN;
         M_DRAIN:   if (!f) mState = M_RUN; else if (!mBusy) mState = M_FLUSHED;
         default:   if (!f) mState = M_RUN;
      endcase
   endtask

   task automatic resetMidOp();
      applyStimulus('1, 1'b0, 1'b1);
      applyStimulus('1, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      req_valid = '1;
      #1;
      rst_n = 1'b0;
      #2;
      checkResetOutputs("rst_mid");
      sb.delete();
      mPtr   = 0;
      mState = M_RUN;
      for (int i = 0; i < NREQ; i++) cnt[i] = 0;
      repeat (2) begin
         @(posedge clk);
         #4;
         checkResetOutputs("rst_hold");
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      rst_n     = 1'b1;
   endtask

   // Scoreboard monitor: every response must match the head of the queue at its due cycle.
   always @(negedge clk) begin
      if (rsp_valid != '0) begin
         if (sb.size() == 0) begin
            checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
         end else begin
            monE = sb.pop_front();
            checkOutput("rsp_valid", 64'(rsp_valid), 64'd1 << monE.idx);
            checkOutput("rsp_data",  64'(rsp_data),  64'(monE.data));
            checkOutput("rsp_cycle", 64'(cyc),       64'(monE.cyc));
         end
      end else begin
         checkOutput("rsp_data_idle", 64'(rsp_data), 64'd0);
         if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            monE = sb.pop_front();
            checkOutput("rsp_missing", 64'(rsp_valid), 64'd1 << monE.idx);
         end
      end
   end

   initial begin
      #20000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      flush     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         valA[i] = 0;
         valB[i] = 0;
         cnt[i]  = 0;
      end
      repeat (2) @(posedge clk);
      #4;
      checkResetOutputs("reset");
      @(posedge clk);
      #1;
      req_valid = '0;
      rst_n     = 1'b1;

      $display("[TB] single request on requester 2: 1.0 + 2.0");
      valA[2] = 1;
      valB[2] = 2;
      applyStimulus(4'b0100, 1'b0, 1'b0);
      repeat (ADD_LAT + 1) applyStimulus('0, 1'b0, 1'b1);

      $display("[TB] reset with two operations in flight");
      resetMidOp();

      $display("[TB] fairness with all requesters valid");
      repeat (12) applyStimulus('1, 1'b0, 1'b1);

      $display("[TB] flush with operations in flight");
      repeat (3) applyStimulus('1, 1'b0, 1'b1);
      for (int n = 0; n < 20 && mState != M_FLUSHED; n++) applyStimulus('1, 1'b1, 1'b1);
      repeat (3) applyStimulus('1, 1'b1, 1'b1);
      repeat (5) applyStimulus('1, 1'b0, 1'b1);

      $display("[TB] flush dropped before the drain completes");
      repeat (2) applyStimulus('1, 1'b0, 1'b1);
      applyStimulus('1, 1'b1, 1'b1);
      repeat (6) applyStimulus('1, 1'b0, 1'b1);

      $display("[TB] random traffic with occasional flushes");
      for (int n = 0; n < 400; n++) begin
         if (hold == 0 && $urandom_range(0, 19) == 0) hold = int'($urandom_range(1, 8));
         applyStimulus(NREQ'($urandom), hold != 0, 1'b1);
         if (hold > 0) hold--;
      end

`ifdef ADD_SHARE_STATS_EN
      $display("[TB] saturating grant counter on requester 1");
      repeat (70000) applyStimulus(4'b0010, 1'b0, 1'b1);
      applyStimulus('0, 1'b0, 1'b1);
      checkOutput("stat_sat", 64'(stat_grants[31:16]), 64'hFFFF);
`else
      applyStimulus('0, 1'b0, 1'b1);
      checkOutput("stat_zero", 64'(stat_grants), 64'd0);
`endif

      repeat (ADD_LAT + 2) applyStimulus('0, 1'b0, 1'b1);
      checkOutput("sb_empty", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/add_share_arb.md
ADD_SHARE_ARB -- requirements
Module: add_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one fp16 adder.
REQ-002 SHALL have parameter ADD_LAT, default 3: fixed adder latency in clk cycles, legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, NREQ bits: per-requester operand pair valid.
REQ-006 SHALL have port req_ready, output, NREQ bits: one-hot grant; at most one bit high per cycle.
REQ-007 SHALL have port req_a, input, NREQ*16 bits: fp16 operand A, requester i at bits [16i+15:16i].
REQ-008 SHALL have port req_b, input, NREQ*16 bits: fp16 operand B, same packing as req_a.
REQ-009 SHALL have port add_a, output, 16 bits: operand A to the shared adder.
REQ-010 SHALL have port add_b, output, 16 bits: operand B to the shared adder.
REQ-011 SHALL have port add_r, input, 16 bits: adder result, valid ADD_LAT cycles after operands are presented.
REQ-012 SHALL have port rsp_valid, output, NREQ bits: one-hot, one-cycle result pulse to the owning requester; no backpressure.
REQ-013 SHALL have port rsp_data, output, 16 bits: result accompanying rsp_valid.
REQ-014 SHALL have port flush, input, 1 bit: stop granting and drain the pipeline.
REQ-015 SHALL have port flush_done, output, 1 bit: high while drained and flush is held.
REQ-016 SHALL have port busy, output, 1 bit: high when any operation is in flight.
REQ-017 SHALL have port stat_grants, output, NREQ*16 bits: per-requester grant counters.

Function
REQ-018 SHALL perform transfer i when req_valid[i] and req_ready[i] are both high on the same edge; req_ready SHALL NOT depend combinationally on req_a or req_b.
REQ-019 SHALL arbitrate round-robin: priority starts at the index after the last granted requester, is index 0 after reset, and advances only on a transfer.
REQ-020 SHALL drive add_a and add_b combinationally from the granted requester's operands and SHALL drive 0 when there is no grant.
REQ-021 SHALL carry a valid bit plus requester index through an ADD_LAT-deep shift register and, when the valid bit emerges, pulse rsp_valid[index] with rsp_data = add_r.
REQ-022 SHALL sustain one accepted operation per cycle and return results in issue order.
REQ-023 SHALL implement a state machine with states RUN, DRAIN and FLUSHED.
REQ-024 SHALL transition RUN to DRAIN when flush is high, with no grant issued in that cycle.
REQ-025 SHALL transition DRAIN to FLUSHED when the in-flight shift register is empty.
REQ-026 SHALL transition FLUSHED to RUN when flush is low.
REQ-027 SHALL transition DRAIN to RUN when flush drops before the drain completes, with results still delivered.
REQ-028 SHALL assert flush_done only in FLUSHED.
REQ-029 SHALL assert busy whenever any shift-register valid bit is set.
REQ-030 SHALL hold rsp_data at 0 when no rsp_valid bit is high.
REQ-031 SHALL allow a new grant and a result for the same requester in the same cycle, both processed independently.

Reset
REQ-032 SHALL, on rst_n low, immediately clear req_ready, rsp_valid, rsp_data, busy, flush_done, stat_grants, the shift register and the round-robin pointer, and enter RUN.
REQ-033 SHALL discard in-flight operations on reset mid-operation, with no rsp_valid emitted afterwards for them.

Configuration
REQ-034 SHALL, with ADD_SHARE_STATS_EN defined, increment stat_grants[i] (16-bit, saturating at 0xFFFF) on each transfer from requester i.
REQ-035 SHALL, without ADD_SHARE_STATS_EN, keep the stat_grants port, tie it to 0 and instantiate no counters.

Structure
REQ-036 SHALL place the FP16_W=16 constant, the state enum (RUN/DRAIN/FLUSHED) and the in-flight tag typedef (valid + index) in package add_share_pkg.
REQ-037 SHALL implement round-robin selection in one sub-module, rr_arb, and nothing else.

Verification
REQ-038 SHALL verify single request: req_valid[2]=1, A=0x3C00, B=0x4000 -> req_ready[2] same cycle; rsp_valid[2] pulse with rsp_data=0x4200 exactly ADD_LAT cycles later.
REQ-039 SHALL verify fairness: all four requesters continuously valid -> grants 0,1,2,3,0,... one per cycle; responses in the same order.
REQ-040 SHALL verify flush: flush raised with 3 ops in flight -> no grants; 3 responses delivered; flush_done=1 on the cycle after the shift register empties; flush low -> grants resume.
REQ-041 SHALL verify reset: rst_n low with 2 ops in flight -> all outputs 0 immediately; no rsp_valid after release; first grant goes to requester 0.
REQ-042 SHALL verify stats: 70000 transfers from requester 1 with ADD_SHARE_STATS_EN defined -> stat_grants[1]=0xFFFF; without the macro, stat_grants=0 throughout.
